photon_gate_counter: RTL and testbench
======================================

Name: photon_gate_counter

Overview:
Upstream stage of the pulse-histogram drawer. It counts photon-detector pulses on an asynchronous input over a fixed gate window. At the end of each window it publishes one scaled, saturated 16-bit count with a one-cycle update strobe. The drawer latches that count on the strobe and appends it to the SDRAM ring buffer.

Parameters:
GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); must be >= 4.
CNT_W, 32, width of the raw pulse accumulator.
OUT_W, 16, width of the published count.
SYNC_STAGES, 2, synchronizer flops on iPhoton; must be >= 2.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  counting enable.
iPhoton  in  1  asynchronous detector pulse; active high.
iScaleShift  in  4  right-shift applied to the raw count before publishing.
oDataUpdate  out  1  one-cycle strobe; new oPulseCounter is valid.
oPulseCounter  out  OUT_W  scaled, saturated count of the last window.
oRawCount  out  CNT_W  unscaled count of the last window.
oOverflow  out  1  last window saturated: either the raw count or the scaled result.
oGateActive  out  1  high while a window is being timed.

Behaviour:
- Reset: all outputs 0; synchronizer, edge register, gate timer and accumulator all 0. Reset mid-window discards the partial window; no strobe is issued.
- Input path:
  - SYNC_STAGES-flop synchronizer, then a one-flop edge detector.
  - A pulse is one rising edge of the synchronized signal.
  - Latency from the iPhoton rise to the accumulator increment is SYNC_STAGES+1 cycles.
  - Minimum countable period is 2 clk cycles (high 1, low 1). Faster input is undefined.
- States: IDLE, GATE, PUBLISH.
- IDLE:
  - Entered on reset or whenever en=0.
  - Timer=0, accumulator=0, oGateActive=0.
  - oPulseCounter, oRawCount and oOverflow hold their last values.
  - Goes to GATE on the first cycle with en=1.
- GATE:
  - oGateActive=1.
  - Timer counts 0..GATE_CYCLES-1. Each edge increments the accumulator; the accumulator saturates at 2^CNT_W-1 and sets an internal sticky raw-overflow flag.
  - On the terminal cycle (timer = GATE_CYCLES-1):
    - The final value includes any edge arriving in that same cycle and is captured to a holding register.
    - iScaleShift is sampled.
    - Timer and accumulator clear.
    - Next state is PUBLISH.
  - If en=0 at any cycle in GATE: go to IDLE and discard the window.
- PUBLISH (exactly 1 cycle):
  - scaled = held >> shift. If scaled > 2^OUT_W-1, or the raw flag is set, oPulseCounter = 2^OUT_W-1 and oOverflow=1. Otherwise oPulseCounter = scaled and oOverflow=0.
  - oRawCount = held; oDataUpdate=1 for this cycle only.
  - The next window is already being timed: timer=0 in PUBLISH, and edges seen in PUBLISH count toward it. oGateActive stays 1.
  - Next state is GATE, or IDLE if en=0. The strobe is still issued even when en has dropped.
- Timing and ordering:
  - Window period is exactly GATE_CYCLES+1 cycles including PUBLISH, so the strobe period equals GATE_CYCLES+1.
  - The strobe rises exactly 1 cycle after the terminal cycle.
  - Outputs are stable between strobes.
  - No edge is lost or double-counted across the window boundary.
- iScaleShift changes mid-window take effect only at the next terminal cycle.
- Arithmetic is unsigned throughout. The shift is a logical right shift of CNT_W bits; saturation is checked before truncation to OUT_W.

Decomposition:
- Shared package (photon_pkg): default GATE_CYCLES, CNT_W, OUT_W, state encoding constants (IDLE=0, GATE=1, PUBLISH=2), and the OUT_W full-scale constant.
- One sub-module: pulse_sync_edge. It holds the SYNC_STAGES synchronizer plus the rising-edge detector and outputs a single-cycle edge pulse.

Test Plan (sim with GATE_CYCLES=100 unless stated):
- Reset: rst_n low 5 cycles, then assert mid-window after 40 cycles. All outputs are 0 and no oDataUpdate appears for 101 cycles after release with en=0.
- en=1, shift=0, 10 pulses (2 high/3 low) in the window. Strobe fires 1 cycle after the terminal cycle: oPulseCounter=10, oRawCount=10, oOverflow=0. The next strobe follows exactly 101 cycles later.
- shift=2, 37 pulses. oPulseCounter=9, oRawCount=37. Change shift to 0 mid-window; that window still reports 9, and the following window uses shift=0.
- GATE_CYCLES=150000, shift=0, 70000 pulses. oPulseCounter=65535, oOverflow=1, oRawCount=70000. Same run with shift=1: oPulseCounter=35000, oOverflow=0.
- Boundary: an edge registered in the terminal cycle counts in the closing window (count N+1). An edge in the PUBLISH cycle appears in the next window's count.
- Deassert en at cycle 60 of a window: no strobe, outputs hold previous values. Reassert: a full new window starts and the first strobe arrives 100 cycles after reassertion plus 1.

Source files
------------

// File: rtl/photon_pkg.sv
// Shared constants for the photon gate counter: default sizing, the FSM state
// encoding and the full-scale value of the published count.
// Latency: n/a (declarations only). Backpressure: n/a.
package photon_pkg;

  localparam int unsigned GATE_CYCLES_DEF = 50_000_000;  // 1 s at 50 MHz
  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned OUT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GATE    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  // All-ones value of a w-bit unsigned quantity.
  function automatic logic [63:0] full_scale(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  localparam logic [OUT_W_DEF-1:0] OUT_FULL_SCALE = OUT_W_DEF'(full_scale(OUT_W_DEF));

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronizes the asynchronous detector input and emits a one-cycle pulse per
// rising edge. Latency: SYNC_STAGES cycles from input rise to edge_o high.
// Backpressure: none; every edge is reported exactly once.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_i    : raw detector pulse (asynchronous to clk)
//   edge_o     : single-cycle rising-edge strobe (combinational from flops)
module pulse_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/photon_gate_counter.sv
// Counts detector pulses over a fixed gate window and publishes a scaled,
// saturated count with a one-cycle strobe. Latency: strobe 1 cycle after the
// terminal gate cycle; iPhoton rise to count is SYNC_STAGES+1 cycles.
// Backpressure: none; the consumer must latch on oDataUpdate.
//   en            : counting enable; low aborts the current window
//   iPhoton       : asynchronous detector pulse, active high
//   iScaleShift   : right shift applied to the raw count at window close
//   oDataUpdate   : one-cycle strobe, outputs below are new
//   oPulseCounter : scaled, saturated count of the last window
//   oRawCount     : unscaled count of the last window
//   oOverflow     : last window saturated (raw or scaled)
//   oGateActive   : a window is being timed
module photon_gate_counter
  import photon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned OUT_W       = OUT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             iPhoton,
  input  logic [3:0]       iScaleShift,
  output logic             oDataUpdate,
  output logic [OUT_W-1:0] oPulseCounter,
  output logic [CNT_W-1:0] oRawCount,
  output logic             oOverflow,
  output logic             oGateActive
);

  localparam int unsigned      TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] OUT_MAX  =
      (OUT_W == OUT_W_DEF) ? CNT_W'(OUT_FULL_SCALE) : CNT_W'(full_scale(OUT_W));

  logic             edge_pls;
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             raw_ovf_q, raw_ovf_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] raw_cnt_q, raw_cnt_d;
  logic             ovf_q, ovf_d;
  logic             upd_q, upd_d;

  logic             acc_full;
  logic [CNT_W-1:0] acc_inc;
  logic             acc_sat;
  logic [CNT_W-1:0] scaled;
  logic             pub_ovf;
  logic [OUT_W-1:0] pub_val;

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(iPhoton),
    .edge_o (edge_pls)
  );

  // Accumulator value including this cycle's edge; it sticks at all-ones and
  // the raw-overflow flag remembers that a count was dropped.
  assign acc_full = (acc_q == CNT_MAX);
  assign acc_inc  = (edge_pls && !acc_full) ? acc_q + CNT_W'(1) : acc_q;
  assign acc_sat  = raw_ovf_q | (edge_pls & acc_full);

  // Published values are computed in the terminal cycle and registered, so
  // they appear together with the strobe in the PUBLISH cycle. Saturation is
  // judged on the full-width shifted value before truncation.
  assign scaled  = acc_inc >> iScaleShift;
  assign pub_ovf = acc_sat || (scaled > OUT_MAX);
  assign pub_val = pub_ovf ? OUT_W'(OUT_MAX) : scaled[OUT_W-1:0];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    acc_d     = acc_q;
    raw_ovf_d = raw_ovf_q;
    out_d     = out_q;
    raw_cnt_d = raw_cnt_q;
    ovf_d     = ovf_q;
    upd_d     = 1'b0;
    case (state_q)
      ST_GATE: begin
        if (!en) begin
          state_d   = ST_IDLE;
          timer_d   = '0;
          acc_d     = '0;
          raw_ovf_d = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          raw_cnt_d = acc_inc;
          out_d     = pub_val;
          ovf_d     = pub_ovf;
          upd_d     = 1'b1;
          timer_d   = '0;
          acc_d     = '0;
          raw_ovf_d = 1'b0;
          state_d   = ST_PUBLISH;
        end else begin
          timer_d   = timer_q + TMR_W'(1);
          acc_d     = acc_inc;
          raw_ovf_d = acc_sat;
        end
      end
      // The next window is already open here: edges count, timer stays at 0
      // so the window period is GATE_CYCLES+1.
      ST_PUBLISH: begin
        if (!en) begin
          state_d   = ST_IDLE;
          timer_d   = '0;
          acc_d     = '0;
          raw_ovf_d = 1'b0;
        end else begin
          state_d   = ST_GATE;
          timer_d   = '0;
          acc_d     = acc_inc;
          raw_ovf_d = acc_sat;
        end
      end
      default: begin
        timer_d   = '0;
        acc_d     = '0;
        raw_ovf_d = 1'b0;
        if (en) state_d = ST_GATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      acc_q     <= '0;
      raw_ovf_q <= 1'b0;
      out_q     <= '0;
      raw_cnt_q <= '0;
      ovf_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      acc_q     <= acc_d;
      raw_ovf_q <= raw_ovf_d;
      out_q     <= out_d;
      raw_cnt_q <= raw_cnt_d;
      ovf_q     <= ovf_d;
      upd_q     <= upd_d;
    end
  end

  assign oDataUpdate   = upd_q;
  assign oPulseCounter = out_q;
  assign oRawCount     = raw_cnt_q;
  assign oOverflow     = ovf_q;
  assign oGateActive   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_photon_gate_counter.sv
module tb_photon_gate_counter;

  localparam int G1 = 100;
  localparam int S1 = 2;
  localparam int G2 = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: GATE_CYCLES=100, default widths.
  logic        rst_n, en, ph;
  logic [3:0]  sh;
  logic        upd, ovf, gate;
  logic [15:0] pc;
  logic [31:0] raw;

  photon_gate_counter #(.GATE_CYCLES(G1), .CNT_W(32), .OUT_W(16), .SYNC_STAGES(S1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iPhoton(ph), .iScaleShift(sh),
    .oDataUpdate(upd), .oPulseCounter(pc), .oRawCount(raw),
    .oOverflow(ovf), .oGateActive(gate)
  );

  // Narrow instance for raw and scaled saturation: CNT_W=7, OUT_W=6.
  logic       rst2_n, en2, ph2;
  logic [3:0] sh2;
  logic       upd2, ovf2, gate2;
  logic [5:0] pc2;
  logic [6:0] raw2;

  photon_gate_counter #(.GATE_CYCLES(G2), .CNT_W(7), .OUT_W(6), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .iPhoton(ph2), .iScaleShift(sh2),
    .oDataUpdate(upd2), .oPulseCounter(pc2), .oRawCount(raw2),
    .oOverflow(ovf2), .oGateActive(gate2)
  );

  typedef struct {
    int n;   // pulses in the train
    int hi;  // train high cycles
    int lo;  // train low cycles
    int sh;  // scale shift for this window
    int ex;  // offset of one extra single-cycle pulse (0 = none)
    bit rnd; // random iPhoton, expectations from the reference model
    int eo;  // expected oPulseCounter
    int er;  // expected oRawCount
    int ev;  // expected oOverflow
  } vec_t;

  vec_t tab[9];
  vec_t tab2[7];

  int checks = 0;
  int errors = 0;
  bit inst2_done = 1'b0;

  logic [63:0] p_out = '0, p_raw = '0, p_ovf = '0;
  int edge_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drives iPhoton and records, for each rising edge, the clock count at
  // which the counter absorbs it (SYNC_STAGES+1 edges after sampling).
  task automatic set_ph(input logic v);
    if (v && !ph) edge_q.push_back(cyc + S1 + 1);
    ph = v;
  endtask

  // Reference: the window holds every edge absorbed after the previous strobe
  // up to and including this one; then saturate, shift, saturate again.
  task automatic model(input longint c, input int s, input int cw, input int ow,
                       output longint eo, output longint er, output longint ev);
    longint cmax, omax, sc;
    bit rs;
    cmax = (longint'(1) << cw) - 1;
    omax = (longint'(1) << ow) - 1;
    rs   = (c > cmax);
    er   = rs ? cmax : c;
    sc   = er >> s;
    ev   = (rs || sc > omax) ? 1 : 0;
    eo   = (ev != 0) ? omax : sc;
  endtask

  // Entered between posedge t0 and t0+1, where t0 is the previous strobe
  // cycle (or the cycle en was raised). Returns the cycle of the new strobe.
  task automatic run_window(input int t0, input vec_t v, input string tag, output int t1);
    int idx, per, cnt;
    longint mo, mr, mv;
    logic [63:0] eo, er, ev;
    per = v.hi + v.lo;
    for (int o = 1; o <= G1; o++) begin
      @(posedge clk); #1;
      if (o == 1) begin
        sh = 4'(v.sh);
        chk({tag, "_strobe_fall"}, upd, 0);
      end
      if (v.rnd) set_ph(1'($urandom_range(0, 1)));
      else begin
        idx = o - 1;
        set_ph((v.n > 0 && idx / per < v.n && idx % per < v.hi) || o == v.ex);
      end
      if (o == 50) begin
        chk({tag, "_hold_out"}, pc, p_out);
        chk({tag, "_hold_raw"}, raw, p_raw);
        chk({tag, "_hold_ovf"}, ovf, p_ovf);
        chk({tag, "_gate_active"}, gate, 1);
      end
    end
    t1 = -1;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      @(negedge clk);
      if (upd === 1'b1) t1 = cyc;
    end
    if (t1 < 0) begin
      checks++; errors++;
      $display("FAIL %s_strobe: none within budget after cycle %0d", tag, t0);
      t1 = cyc;
    end else chk({tag, "_period"}, t1 - t0, G1 + 1);
    cnt = 0;
    while (edge_q.size() > 0 && edge_q[0] <= t1) begin
      void'(edge_q.pop_front());
      cnt++;
    end
    if (v.rnd) begin
      model(cnt, v.sh, 32, 16, mo, mr, mv);
      eo = mo; er = mr; ev = mv;
    end else begin
      eo = v.eo; er = v.er; ev = v.ev;
    end
    chk({tag, "_count"}, pc, eo);
    chk({tag, "_raw"}, raw, er);
    chk({tag, "_ovf"}, ovf, ev);
    p_out = eo; p_raw = er; p_ovf = ev;
  endtask

  initial begin
    vec_t v;
    int t, nstb, nz;
    //          n  hi lo sh ex rnd eo  er  ev
    tab[0] = '{10, 2, 3, 0,  0, 0, 10, 10, 0};
    tab[1] = '{37, 1, 1, 2,  0, 0,  9, 37, 0};
    tab[2] = '{37, 1, 1, 0,  0, 0, 37, 37, 0};  // shift changed after last close
    tab[3] = '{ 0, 1, 1, 3,  0, 0,  0,  0, 0};
    tab[4] = '{49, 1, 1, 5,  0, 0,  1, 49, 0};
    tab[5] = '{ 5, 1, 1, 0, 98, 0,  6,  6, 0};  // extra edge lands in terminal cycle
    tab[6] = '{ 3, 1, 1, 0, 99, 0,  3,  3, 0};  // extra edge lands in PUBLISH cycle
    tab[7] = '{ 0, 1, 1, 0,  0, 0,  1,  1, 0};  // ...and is reported here
    tab[8] = '{20, 1, 1, 1,  0, 0, 10, 20, 0};
    tab2[0] = '{180, 1, 1, 0, 0, 0, 63, 127, 1};  // raw saturates
    tab2[1] = '{100, 1, 1, 0, 0, 0, 63, 100, 1};  // scaled saturates
    tab2[2] = '{100, 1, 1, 1, 0, 0, 50, 100, 0};
    tab2[3] = '{180, 1, 1, 7, 0, 0, 63, 127, 1};  // raw flag wins over shift
    tab2[4] = '{127, 1, 1, 1, 0, 0, 63, 127, 0};  // raw exactly full, no overflow
    tab2[5] = '{128, 1, 1, 1, 0, 0, 63, 127, 1};  // one past full
    tab2[6] = '{  0, 1, 1, 0, 0, 0,  0,   0, 0};

    rst_n = 1'b0; en = 1'b0; ph = 1'b0; sh = 4'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_upd", upd, 0);
    chk("reset_count", pc, 0);
    chk("reset_raw", raw, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_gate", gate, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_gate", gate, 0);

    en = 1'b1; t = cyc;
    for (int i = 0; i < 9; i++) run_window(t, tab[i], $sformatf("vec%0d", i), t);

    // Drop en at cycle 60 of a window after some pulses: window discarded.
    for (int o = 1; o <= 60; o++) begin
      @(posedge clk); #1;
      set_ph(o <= 20 && o % 2 == 1);
    end
    en = 1'b0;
    nstb = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (upd !== 1'b0) nstb++;
    end
    chk("drop_no_strobe", nstb, 0);
    chk("drop_hold_out", pc, p_out);
    chk("drop_hold_raw", raw, p_raw);
    chk("drop_hold_ovf", ovf, p_ovf);
    chk("drop_gate", gate, 0);
    edge_q.delete();
    @(posedge clk); #1 en = 1'b1; t = cyc;
    v = '{4, 1, 1, 0, 0, 0, 4, 4, 0};
    run_window(t, v, "reen", t);

    // Reset 40 cycles into a window.
    for (int o = 1; o <= 40; o++) begin
      @(posedge clk); #1;
      set_ph(o % 4 == 1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_count", pc, 0);
    chk("midrst_raw", raw, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_upd", upd, 0);
    chk("midrst_gate", gate, 0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nstb = 0; nz = 0;
    for (int k = 0; k < 101; k++) begin
      @(negedge clk);
      if (upd !== 1'b0) nstb++;
      if (pc !== 0 || raw !== 0 || ovf !== 1'b0 || gate !== 1'b0) nz++;
    end
    chk("midrst_no_strobe", nstb, 0);
    chk("midrst_outputs_zero", nz, 0);
    p_out = '0; p_raw = '0; p_ovf = '0;

    // Random pulse streams against the window model.
    edge_q.delete();
    @(posedge clk); #1 en = 1'b1; t = cyc;
    for (int w = 0; w < 15; w++) begin
      v = '{0, 1, 1, int'($urandom_range(0, 3)), 0, 1, 0, 0, 0};
      run_window(t, v, $sformatf("rnd%0d", w), t);
    end
    en = 1'b0;

    for (int k = 0; k < 20000 && !inst2_done; k++) @(posedge clk);
    if (!inst2_done) begin
      checks++; errors++;
      $display("FAIL sat_done: narrow instance sequence did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int t2, got, idx;
    rst2_n = 1'b0; en2 = 1'b0; ph2 = 1'b0; sh2 = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst2_n = 1'b1;
    @(posedge clk); #1 en2 = 1'b1; t2 = cyc;
    for (int i = 0; i < 7; i++) begin
      for (int o = 1; o <= G2; o++) begin
        @(posedge clk); #1;
        if (o == 1) sh2 = 4'(tab2[i].sh);
        idx = o - 1;
        ph2 = (idx / 2 < tab2[i].n) && (idx % 2 == 0);
        if (o == 200) chk($sformatf("sat%0d_gate", i), gate2, 1);
      end
      got = -1;
      for (int k = 0; k < 20 && got < 0; k++) begin
        @(negedge clk);
        if (upd2 === 1'b1) got = cyc;
      end
      if (got < 0) begin
        checks++; errors++;
        $display("FAIL sat%0d_strobe: none within budget", i);
        got = cyc;
      end else chk($sformatf("sat%0d_period", i), got - t2, G2 + 1);
      chk($sformatf("sat%0d_count", i), pc2, tab2[i].eo);
      chk($sformatf("sat%0d_raw", i), raw2, tab2[i].er);
      chk($sformatf("sat%0d_ovf", i), ovf2, tab2[i].ev);
      t2 = got;
    end
    en2 = 1'b0;
    inst2_done = 1'b1;
  end

endmodule
